dram_image_reader: RTL



---
 rtl/dram_image_reader.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/dram_image_reader.sv
// dram_image_reader: replays one captured image from DRAM as a back-pressured 512-bit beat stream.
// A burst is requested only when the output FIFO can absorb all of it, so unstallable read data is never lost.

module dram_image_reader_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic full
);
  // A push into a full FIFO means the burst credit check has been broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

module dram_image_reader #(
  parameter int                         DRAM_ADDR_WIDTH = 48,
  parameter logic [DRAM_ADDR_WIDTH-1:0] DRAM_ADDR_BASE  = 48'h4_0000_0000,
  parameter int                         DRAM_DATA_WIDTH = 512,
  parameter int                         IMAGE_NUM_WIDTH = 8,
  parameter int                         BEATS_PER_IMAGE = 1024,
  parameter int                         BURST_LEN       = 16,
  parameter int                         FIFO_DEPTH      = 32
) (
  input  logic                       m_axi_aclk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [IMAGE_NUM_WIDTH-1:0] image_index,
  input  logic [IMAGE_NUM_WIDTH-1:0] captured_image_num,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
  output logic [7:0]                 dram_read_len,
  output logic                       dram_read_en,
  input  logic                       dram_read_busy,
  input  logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
  input  logic                       dram_read_data_valid,
  output logic [DRAM_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast
);
  localparam int BYTES_PER_BEAT = DRAM_DATA_WIDTH / 8;
  localparam int NUM_BURSTS     = BEATS_PER_IMAGE / BURST_LEN;
  localparam int AW             = $clog2(FIFO_DEPTH);
  localparam int BW             = $clog2(BURST_LEN + 1);
  localparam int CW             = $clog2(NUM_BURSTS + 1);
  localparam int OW             = $clog2(BEATS_PER_IMAGE + 1);
  localparam logic [DRAM_ADDR_WIDTH-1:0] IMG_BYTES   = DRAM_ADDR_WIDTH'(BEATS_PER_IMAGE * BYTES_PER_BEAT);
  localparam logic [DRAM_ADDR_WIDTH-1:0] BURST_BYTES = DRAM_ADDR_WIDTH'(BURST_LEN * BYTES_PER_BEAT);
  // A request fits when occupancy leaves at least BURST_LEN free slots.
  localparam logic [AW:0] MAX_OCC = (AW+1)'(FIFO_DEPTH - BURST_LEN);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RECV = 2'd2, DRAIN = 2'd3} state_t;

  state_t                     state_r, state_nx_s;
  logic                       accept_s, reject_s, push_s, pop_s, burst_end_s, finish_s;
  logic                       empty_s, full_s;
  logic                       busy_r, done_r, error_r;
  logic [DRAM_ADDR_WIDTH-1:0] addr_r;
  logic [7:0]                 len_r;
  logic [BW-1:0]              beat_in_burst_r;
  logic [CW-1:0]              burst_cnt_r;
  logic [OW-1:0]              out_cnt_r;
  logic [AW-1:0]              wr_ptr_r, rd_ptr_r;
  logic [AW:0]                count_r;
  logic [DRAM_DATA_WIDTH-1:0] fifo_mem_r [0:FIFO_DEPTH-1];

  assign empty_s        = (count_r == {(AW+1){1'b0}});
  assign full_s         = (count_r == (AW+1)'(FIFO_DEPTH));
  assign pop_s          = !empty_s && m_axis_tready;
  assign m_axis_tvalid  = !empty_s;
  assign m_axis_tlast   = !empty_s && (out_cnt_r == OW'(BEATS_PER_IMAGE - 1));
  assign m_axis_tdata   = empty_s ? {DRAM_DATA_WIDTH{1'b0}} : fifo_mem_r[rd_ptr_r];
  assign busy           = busy_r;
  assign done           = done_r;
  assign error          = error_r;
  assign dram_read_addr = addr_r;
  assign dram_read_len  = len_r;

  // State register.
  always_ff @(posedge m_axi_aclk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nx_s;
  end

  // Next-state logic and per-cycle strobes; ISSUE implies no burst is in flight.
  always_comb begin
    state_nx_s   = state_r;
    dram_read_en = 1'b0;
    accept_s     = 1'b0;
    reject_s     = 1'b0;
    push_s       = 1'b0;
    burst_end_s  = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && (image_index >= captured_image_num)) begin
          reject_s = 1'b1;
        end else if (start) begin
          accept_s   = 1'b1;
          state_nx_s = ISSUE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ISSUE: begin
        if (!dram_read_busy && (count_r <= MAX_OCC)) begin
          dram_read_en = 1'b1;
          state_nx_s   = RECV;
        end else begin
          state_nx_s = ISSUE;
        end
      end
      RECV: begin
        if (dram_read_data_valid) begin
          push_s = 1'b1;
          if (beat_in_burst_r == BW'(BURST_LEN - 1)) begin
            burst_end_s = 1'b1;
            state_nx_s  = (burst_cnt_r == CW'(NUM_BURSTS - 1)) ? DRAIN : ISSUE;
          end else begin
            state_nx_s = RECV;
          end
        end else begin
          state_nx_s = RECV;
        end
      end
      DRAIN: begin
        if (pop_s && m_axis_tlast) begin
          finish_s   = 1'b1;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DRAIN;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Request bookkeeping, burst address and status pulses.
  always_ff @(posedge m_axi_aclk or posedge reset) begin
    if (reset) begin
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      error_r         <= 1'b0;
      addr_r          <= {DRAM_ADDR_WIDTH{1'b0}};
      len_r           <= 8'd0;
      beat_in_burst_r <= {BW{1'b0}};
      burst_cnt_r     <= {CW{1'b0}};
      out_cnt_r       <= {OW{1'b0}};
    end else begin
      done_r  <= finish_s;
      error_r <= reject_s;
      if (accept_s) begin
        busy_r          <= 1'b1;
        addr_r          <= DRAM_ADDR_BASE + DRAM_ADDR_WIDTH'(image_index) * IMG_BYTES;
        len_r           <= 8'(BURST_LEN - 1);
        beat_in_burst_r <= {BW{1'b0}};
        burst_cnt_r     <= {CW{1'b0}};
        out_cnt_r       <= {OW{1'b0}};
      end else begin
        if (finish_s) busy_r <= 1'b0;
        if (burst_end_s) begin
          beat_in_burst_r <= {BW{1'b0}};
          burst_cnt_r     <= burst_cnt_r + CW'(1);
          addr_r          <= addr_r + BURST_BYTES;
        end else if (push_s) begin
          beat_in_burst_r <= beat_in_burst_r + BW'(1);
        end
        if (pop_s) out_cnt_r <= out_cnt_r + OW'(1);
      end
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge m_axi_aclk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage, unreset since only occupied slots are ever presented.
  always_ff @(posedge m_axi_aclk) begin
    if (push_s) fifo_mem_r[wr_ptr_r] <= dram_read_data;
  end

  dram_image_reader_chk u_chk (
    .clk  (m_axi_aclk),
    .rst  (reset),
    .push (push_s),
    .full (full_s)
  );
endmodule
